// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types and port indices for the shared divider sequencer
package exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam logic REQ_INT = 1'b0;
  localparam logic REQ_FPU = 1'b1;

  function automatic logic [1:0] port_mask(input logic port);
    return (port == REQ_FPU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - restoring shift-subtract datapath, one quotient bit per step, MSB first
module div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0]   dividend;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   mask;
  logic [2*XLEN-2:0] divisor;

  // A zero divisor always compares <= and subtracts nothing, giving all-ones / a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      quo      <= '0;
      mask     <= '0;
      divisor  <= '0;
    end else if (load) begin
      dividend <= a;
      quo      <= '0;
      mask     <= {1'b1, {(XLEN-1){1'b0}}};
      divisor  <= {b, {(XLEN-1){1'b0}}};
    end else if (step) begin
      if (divisor <= {{(XLEN-1){1'b0}}, dividend}) begin
        dividend <= dividend - divisor[XLEN-1:0];
        quo      <= quo | mask;
      end
      divisor <= divisor >> 1;
      mask    <= mask >> 1;
    end
  end

  assign quotient  = quo;
  assign remainder = dividend;

endmodule

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - two-port arbiter/sequencer for one shared iterative divider
module div_share_ctrl
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [1:0]         req_valid_i,
  input  logic [2*XLEN-1:0]  req_a_i,
  input  logic [2*XLEN-1:0]  req_b_i,
  input  logic [1:0]         req_signed_i,
  input  logic [1:0]         req_rem_i,
  input  logic [2*TAG_W-1:0] req_tag_i,
  input  logic [1:0]         kill_i,
  output logic [1:0]         gnt_o,
  output logic [1:0]         resp_valid_o,
  input  logic [1:0]         resp_ack_i,
  output logic [XLEN-1:0]    resp_data_o,
  output logic [TAG_W-1:0]   resp_tag_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_t       state, next_state;
  logic             last_grant, owner, winner, grant;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, rem_sel;
  logic [TAG_W-1:0] tag;
  logic             core_load, core_step;
  logic [XLEN-1:0]  sel_a, sel_b, op_a, op_b, quo, rmd, base, fixed;
  logic             sel_signed, sel_rem;
  logic [TAG_W-1:0] sel_tag;

  assign sel_a      = (owner == REQ_INT) ? req_a_i[XLEN-1:0]   : req_a_i[2*XLEN-1:XLEN];
  assign sel_b      = (owner == REQ_INT) ? req_b_i[XLEN-1:0]   : req_b_i[2*XLEN-1:XLEN];
  assign sel_tag    = (owner == REQ_INT) ? req_tag_i[TAG_W-1:0] : req_tag_i[2*TAG_W-1:TAG_W];
  assign sel_signed = req_signed_i[owner];
  assign sel_rem    = req_rem_i[owner];
  assign op_a       = (sel_signed && sel_a[XLEN-1]) ? -sel_a : sel_a;
  assign op_b       = (sel_signed && sel_b[XLEN-1]) ? -sel_b : sel_b;

  assign base   = rem_sel ? rmd : quo;
  assign fixed  = (rem_sel ? neg_r : neg_q) ? -base : base;
  assign busy_o = (state != IDLE);

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    winner     = REQ_INT;
    core_load  = 1'b0;
    core_step  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid_i) begin
          grant      = 1'b1;
          winner     = (req_valid_i == 2'b11) ? ~last_grant : req_valid_i[1];
          next_state = LOAD;
        end
      end
      LOAD: begin
        core_load  = 1'b1;
        next_state = kill_i[owner] ? IDLE : RUN;
      end
      RUN: begin
        core_step = 1'b1;
        if (kill_i[owner])                       next_state = IDLE;
        else if (cnt == CNT_W'(XLEN-1))          next_state = DONE;
      end
      DONE: begin
        // Kill takes priority over a same-cycle ack; ack counts only once valid is up.
        if (kill_i[owner])                                  next_state = IDLE;
        else if (resp_valid_o[owner] && resp_ack_i[owner])  next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      last_grant   <= REQ_FPU;
      owner        <= REQ_INT;
      gnt_o        <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
      resp_tag_o   <= '0;
      cnt          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      rem_sel      <= 1'b0;
      tag          <= '0;
    end else begin
      state <= next_state;
      gnt_o <= grant ? port_mask(winner) : 2'b00;
      if (grant) begin
        owner      <= winner;
        last_grant <= winner;
      end
      if (core_load) begin
        cnt     <= '0;
        neg_q   <= sel_signed & (sel_a[XLEN-1] ^ sel_b[XLEN-1]) & (sel_b != '0);
        neg_r   <= sel_signed & sel_a[XLEN-1];
        rem_sel <= sel_rem;
        tag     <= sel_tag;
      end
      if (state == RUN) cnt <= cnt + 1'b1;
      if (state == DONE) begin
        resp_data_o <= fixed;
        resp_tag_o  <= tag;
      end
      resp_valid_o <= (state == DONE && next_state == DONE) ? port_mask(owner) : 2'b00;
    end
  end

  div_core #(.XLEN(XLEN)) u_core (
    .clk       (clk_i),
    .rst_n     (reset_ni),
    .load      (core_load),
    .step      (core_step),
    .a         (op_a),
    .b         (op_b),
    .quotient  (quo),
    .remainder (rmd)
  );

endmodule
